// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and control-bundle types for the pipelined main control.
package pipe_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [1:0] JUMP_NONE   = 2'b00;
  localparam logic [1:0] JUMP_BRANCH = 2'b01;
  localparam logic [1:0] JUMP_JALR   = 2'b10;
  localparam logic [1:0] JUMP_JAL    = 2'b11;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_BCMP = 2'b01;
  localparam logic [1:0] ALUOP_R    = 2'b10;
  localparam logic [1:0] ALUOP_I    = 2'b11;

  localparam logic [1:0] ASEL_RS1  = 2'b00;
  localparam logic [1:0] ASEL_PC   = 2'b01;
  localparam logic [1:0] ASEL_ZERO = 2'b10;

  typedef struct packed {
    logic [1:0] jump;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] a_sel;
    logic       is_muldiv;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

  // Only the fields MEM and WB still consume are carried past EX.
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } wb_ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct7 -> control bundle decoder used in ID.
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter bit ENABLE_MULDIV = 1'b1
) (
  input  logic [6:0]   opcode,
  input  logic [6:0]   funct7,
  output ctrl_bundle_t ctrl
);

  // Unknown opcodes fall through to the all-zero bundle.
  always_comb begin
    ctrl = CTRL_BUBBLE;
    unique case (opcode)
      OP_R: begin
        ctrl.alu_op    = ALUOP_R;
        ctrl.reg_write = 1'b1;
        ctrl.is_muldiv = ENABLE_MULDIV && (funct7 == F7_MULDIV);
      end
      OP_I_ALU: begin
        ctrl.alu_op    = ALUOP_I;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_LOAD: begin
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.jump   = JUMP_BRANCH;
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALUOP_BCMP;
      end
      OP_JAL: begin
        ctrl.jump      = JUMP_JAL;
        ctrl.reg_write = 1'b1;
      end
      OP_JALR: begin
        ctrl.jump      = JUMP_JALR;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_LUI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.a_sel     = ASEL_ZERO;
      end
      OP_AUIPC: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.a_sel     = ASEL_PC;
      end
      default: ctrl = CTRL_BUBBLE;
    endcase
  end

endmodule

// File: rtl/pipe_control.sv
// Pipelined main control: ID decode, ID/EX, EX/MEM, MEM/WB control registers
// and the mul/div EX occupancy counter that stalls the front end.
module pipe_control
  import pipe_ctrl_pkg::*;
#(
  parameter bit ENABLE_MULDIV  = 1'b1,
  parameter int MULDIV_LATENCY = 4,
  parameter int CNT_W          = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [6:0] id_opcode,
  input  logic [6:0] id_funct7,
  input  logic       id_flush,
  input  logic       stall_in,
  input  logic       ex_kill,
  output logic       ex_valid,
  output logic       mem_valid,
  output logic       wb_valid,
  output logic [1:0] ex_jump,
  output logic       ex_branch,
  output logic [1:0] ex_alu_op,
  output logic       ex_alu_src,
  output logic [1:0] ex_a_sel,
  output logic       ex_is_muldiv,
  output logic       ex_mem_read,
  output logic       ex_reg_write,
  output logic       mem_mem_read,
  output logic       mem_mem_write,
  output logic       mem_mem_to_reg,
  output logic       mem_reg_write,
  output logic       wb_mem_to_reg,
  output logic       wb_reg_write,
  output logic       stall_out
);

  if (MULDIV_LATENCY < 1 || MULDIV_LATENCY > 16 || (2 ** CNT_W) <= MULDIV_LATENCY) begin : g_param_check
    $error("pipe_control: MULDIV_LATENCY must be 1..16 and fit in CNT_W bits");
  end

  // Counter reload: the first EX cycle is already spent when it is loaded.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LATENCY - 1);

  ctrl_bundle_t     id_ctrl;
  ctrl_bundle_t     ex_ctrl_q;
  logic             ex_valid_q;
  mem_ctrl_t        mem_ctrl_q;
  logic             mem_valid_q;
  wb_ctrl_t         wb_ctrl_q;
  logic             wb_valid_q;
  logic [CNT_W-1:0] busy_cnt;
  logic             busy;

  ctrl_decode #(.ENABLE_MULDIV(ENABLE_MULDIV)) u_decode (
    .opcode (id_opcode),
    .funct7 (id_funct7),
    .ctrl   (id_ctrl)
  );

  assign busy      = (busy_cnt != '0);
  assign stall_out = busy;

  // ID/EX register and busy counter: kill beats hold, hold beats bubble/load.
  always_ff @(posedge clk) begin
    if (reset || ex_kill) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= CTRL_BUBBLE;
      busy_cnt   <= '0;
    end else if (busy) begin
      busy_cnt <= busy_cnt - 1'b1;
    end else if (stall_in || id_flush || !id_valid) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= CTRL_BUBBLE;
    end else begin
      ex_valid_q <= 1'b1;
      ex_ctrl_q  <= id_ctrl;
      busy_cnt   <= id_ctrl.is_muldiv ? CNT_LOAD : '0;
    end
  end

  // EX/MEM register: an instruction still occupying EX sends a bubble forward.
  always_ff @(posedge clk) begin
    if (reset || busy || ex_kill) begin
      mem_valid_q <= 1'b0;
      mem_ctrl_q  <= '0;
    end else begin
      mem_valid_q           <= ex_valid_q;
      mem_ctrl_q.mem_read   <= ex_ctrl_q.mem_read;
      mem_ctrl_q.mem_write  <= ex_ctrl_q.mem_write;
      mem_ctrl_q.mem_to_reg <= ex_ctrl_q.mem_to_reg;
      mem_ctrl_q.reg_write  <= ex_ctrl_q.reg_write;
    end
  end

  // MEM/WB register: never stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_ctrl_q  <= '0;
    end else begin
      wb_valid_q           <= mem_valid_q;
      wb_ctrl_q.mem_to_reg <= mem_ctrl_q.mem_to_reg;
      wb_ctrl_q.reg_write  <= mem_ctrl_q.reg_write;
    end
  end

  assign ex_valid       = ex_valid_q;
  assign ex_jump        = ex_ctrl_q.jump;
  assign ex_branch      = ex_ctrl_q.branch;
  assign ex_alu_op      = ex_ctrl_q.alu_op;
  assign ex_alu_src     = ex_ctrl_q.alu_src;
  assign ex_a_sel       = ex_ctrl_q.a_sel;
  assign ex_is_muldiv   = ex_ctrl_q.is_muldiv;
  assign ex_mem_read    = ex_ctrl_q.mem_read;
  assign ex_reg_write   = ex_ctrl_q.reg_write;
  assign mem_valid      = mem_valid_q;
  assign mem_mem_read   = mem_ctrl_q.mem_read;
  assign mem_mem_write  = mem_ctrl_q.mem_write;
  assign mem_mem_to_reg = mem_ctrl_q.mem_to_reg;
  assign mem_reg_write  = mem_ctrl_q.reg_write;
  assign wb_valid       = wb_valid_q;
  assign wb_mem_to_reg  = wb_ctrl_q.mem_to_reg;
  assign wb_reg_write   = wb_ctrl_q.reg_write;

endmodule

// File: doc/pipe_control.md
Name: pipe_control

Overview:
- Pipelined main-control unit for the 5-stage RV32 core; successor to the combinational opcode decoder.
- Decodes the ID-stage opcode/funct7 into a control bundle, then carries it through ID/EX, EX/MEM and MEM/WB registers with per-stage valid, bubble and hold.
- Adds LUI/AUIPC decode, an operand-A select, and optional M-extension decode with a multi-cycle EX occupancy counter that generates a pipeline stall.

Parameters:
- ENABLE_MULDIV, 1, decode funct7=0000001 R-type as mul/div; 0 = treat as plain R-type.
- MULDIV_LATENCY, 4, cycles a mul/div occupies EX (legal 1..16).
- CNT_W, 4, busy-counter width; must satisfy 2^CNT_W > MULDIV_LATENCY.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  7  instruction[6:0]
- id_funct7  in  7  instruction[31:25]
- id_flush  in  1  squash ID instruction (branch/jump redirect)
- stall_in  in  1  load-use stall from hazard unit
- ex_kill  in  1  squash EX instruction, including an in-flight mul/div
- ex_valid, mem_valid, wb_valid  out  1 each  stage holds a live instruction
- ex_jump  out  2  00 none, 01 branch, 10 JALR, 11 JAL
- ex_branch  out  1
- ex_alu_op  out  2  00 add, 01 branch compare, 10 R funct, 11 I funct
- ex_alu_src  out  1  1 = immediate
- ex_a_sel  out  2  00 rs1, 01 PC, 10 zero
- ex_is_muldiv  out  1
- ex_mem_read, ex_reg_write  out  1 each  for hazard/forwarding
- mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write  out  1 each
- wb_mem_to_reg, wb_reg_write  out  1 each
- stall_out  out  1  mul/div busy; freezes PC and IF/ID upstream

Behaviour:
- Decode is combinational in ID. Bundle order: {jump, branch, mem_read, mem_to_reg, alu_op, mem_write, alu_src, reg_write, a_sel, is_muldiv}.
  - R 0110011: alu_op=10, reg_write=1; is_muldiv = ENABLE_MULDIV && funct7==0000001.
  - I-ALU 0010011: alu_op=11, alu_src=1, reg_write=1.
  - Load 0000011: mem_read=1, mem_to_reg=1, alu_src=1, reg_write=1.
  - Store 0100011: mem_write=1, alu_src=1.
  - Branch 1100011: jump=01, branch=1, alu_op=01.
  - JAL 1101111: jump=11, reg_write=1.
  - JALR 1100111: jump=10, alu_src=1, reg_write=1.
  - LUI 0110111: alu_src=1, reg_write=1, a_sel=10.
  - AUIPC 0010111: alu_src=1, reg_write=1, a_sel=01.
  - Any other opcode: all-zero bundle; the stage valid bit still follows id_valid.
- A bubble is an all-zero bundle with valid=0. All stage outputs are 0 on reset and for a bubble.
- busy = (busy_cnt != 0). stall_out = busy, combinational from the register.
- ID/EX update, priority order:
  1. reset -> bubble
  2. ex_kill -> bubble
  3. busy -> hold
  4. stall_in | id_flush | !id_valid -> bubble
  5. otherwise load the decoded bundle
- busy_cnt update:
  - reset or ex_kill -> 0.
  - Decoded is_muldiv loaded into ID/EX -> MULDIV_LATENCY-1.
  - busy -> decrement.
- Net effect: a mul/div occupies EX for exactly MULDIV_LATENCY cycles and stall_out is high for its first MULDIV_LATENCY-1 cycles. MULDIV_LATENCY=1 never stalls.
- EX/MEM: reset, busy or ex_kill -> bubble; otherwise capture ID/EX.
- MEM/WB: always captures EX/MEM; bubble on reset. MEM and WB never stall.
- stall_in asserted while busy has no additional effect (busy dominates).
- id_flush during busy is ignored by this block; upstream holds ID.
- Reset or ex_kill mid-mul/div: counter cleared and EX bubbled on the next edge; instructions already in MEM/WB still complete.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - opcode constants.
  - JUMP_*, ALUOP_*, ASEL_* encodings.
  - packed struct ctrl_bundle_t and constant CTRL_BUBBLE.
- One sub-module, ctrl_decode: the combinational opcode/funct7 -> ctrl_bundle_t decoder, reused by the ID stage.
- Stage registers and the busy counter stay in pipe_control.

Test Plan:
- After reset, id_valid=1 with add (0110011, funct7=0) -> ex_alu_op=10 and ex_reg_write=1 at cycle+1; mem_reg_write=1 at +2; wb_reg_write=1 at +3; stall_out stays 0.
- Load then stall_in=1 for one cycle -> EX gets a bubble (ex_valid=0, all EX controls 0) the cycle after the load leaves EX; no duplicate load reaches MEM.
- mul (funct7=0000001), MULDIV_LATENCY=4 -> ex_is_muldiv=1 for 4 cycles, stall_out=1 for 3; mem_valid=0 during the stall; mul reaches MEM at EX-entry+4.
- Same mul with ENABLE_MULDIV=0 -> ex_is_muldiv=0, stall_out never set, behaves as R-type.
- ex_kill on the second busy cycle -> stall_out=0 and ex_valid=0 next cycle; the mul never reaches MEM.
- Branch in EX with id_flush=1 on the following JAL in ID -> JAL enters EX as a bubble (ex_jump=00).
- LUI -> ex_a_sel=10, ex_alu_src=1. AUIPC -> ex_a_sel=01. Undefined opcode 1111111 -> all-zero bundle with ex_valid=1.
- reset asserted mid-stream -> all outputs 0 on the next edge.
